// File: rtl/joystick_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// jstk_pkg
// Shared types and constants for the PmodJSTK conditioner.
//   dir_t         : move direction encoding (also the Move_Dir output code)
//   fire_state_t  : fire controller states
//   frame slices  : bit positions of X / Y / button fields in the 40-bit frame
//   get_x / get_y : assemble the 10-bit axis values from a raw frame
// ---------------------------------------------------------------------------
package jstk_pkg;

  localparam int JSTK_CENTER = 512;
  localparam int CNT_W       = 26;

  // Frame layout: low byte of each axis comes first in the byte stream,
  // the two MSBs ride in the following byte.
  localparam int X_LO_MSB = 23;
  localparam int X_LO_LSB = 16;
  localparam int X_HI_MSB = 9;
  localparam int X_HI_LSB = 8;
  localparam int Y_LO_MSB = 39;
  localparam int Y_LO_LSB = 32;
  localparam int Y_HI_MSB = 25;
  localparam int Y_HI_LSB = 24;
  localparam int BTN_MSB  = 2;
  localparam int BTN_LSB  = 0;
  localparam int FIRE_BIT = 1;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    RIGHT = 2'b01,
    LEFT  = 2'b10
  } dir_t;

  typedef enum logic {
    FIRE_READY    = 1'b0,
    FIRE_COOLDOWN = 1'b1
  } fire_state_t;

  function automatic logic [9:0] get_x(input logic [39:0] frame);
    return {frame[X_HI_MSB:X_HI_LSB], frame[X_LO_MSB:X_LO_LSB]};
  endfunction

  function automatic logic [9:0] get_y(input logic [39:0] frame);
    return {frame[Y_HI_MSB:Y_HI_LSB], frame[Y_LO_MSB:Y_LO_LSB]};
  endfunction

endpackage

// File: rtl/joystick_conditioner_if.sv
// ---------------------------------------------------------------------------
// joystick_conditioner_if
// Bundles the raw frame input and the conditioned command outputs.
//   master : frame source / command consumer (drives Sample_Tick, Jstk_Data)
//   slave  : the conditioner (drives captured axes, direction, fire signals)
// ---------------------------------------------------------------------------
interface joystick_conditioner_if;
  logic        Sample_Tick;
  logic [39:0] Jstk_Data;
  logic [9:0]  X_Pos;
  logic [9:0]  Y_Pos;
  logic [2:0]  Buttons;
  logic [1:0]  Move_Dir;
  logic        Sample_Valid;
  logic        Fire_Pulse;
  logic        Fire_Ready;

  modport master (
    output Sample_Tick, Jstk_Data,
    input  X_Pos, Y_Pos, Buttons, Move_Dir, Sample_Valid, Fire_Pulse, Fire_Ready
  );

  modport slave (
    input  Sample_Tick, Jstk_Data,
    output X_Pos, Y_Pos, Buttons, Move_Dir, Sample_Valid, Fire_Pulse, Fire_Ready
  );
endinterface

// File: rtl/joystick_conditioner_fire_ctrl.sv
// ---------------------------------------------------------------------------
// jstk_fire_ctrl
// Rate-limited fire command generator with a down-counting cooldown timer.
// Build option: JSTK_AUTOFIRE_EN -> trigger on fire level (held button
// re-fires after each cooldown); otherwise trigger on press edge only.
//
// state         | meaning
// FIRE_READY    | waiting for a trigger at a sample edge
// FIRE_COOLDOWN | counter running; triggers are discarded
//
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   sample_edge  : one-cycle strobe for a new frame
//   fire_bit     : fire button level from the new frame
//   o_fire_pulse : one-cycle fire command
//   o_fire_ready : high while in FIRE_READY
// ---------------------------------------------------------------------------
module jstk_fire_ctrl
  import jstk_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_edge,
  input  logic fire_bit,
  output logic o_fire_pulse,
  output logic o_fire_ready
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

  fire_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_prev;
  logic             r_fire_pulse;
  logic             r_fire_ready;
  logic             w_trig;

`ifdef JSTK_AUTOFIRE_EN
  logic w_unused_prev;
  assign w_unused_prev = r_btn_prev;
  assign w_trig        = fire_bit;
`else
  assign w_trig = fire_bit & ~r_btn_prev;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FIRE_READY;
      r_cnt        <= '0;
      r_btn_prev   <= 1'b0;
      r_fire_pulse <= 1'b0;
      r_fire_ready <= 1'b1;
    end else begin
      r_fire_pulse <= 1'b0;
      // Previous-button tracking runs regardless of state so a press held
      // through cooldown is not mistaken for a fresh press afterwards.
      if (sample_edge) begin
        r_btn_prev <= fire_bit;
      end
      case (r_state)
        FIRE_READY: begin
          if (sample_edge && w_trig) begin
            r_fire_pulse <= 1'b1;
            r_fire_ready <= 1'b0;
            r_cnt        <= CNT_LOAD;
            r_state      <= FIRE_COOLDOWN;
          end
        end
        FIRE_COOLDOWN: begin
          if (r_cnt == '0) begin
            r_fire_ready <= 1'b1;
            r_state      <= FIRE_READY;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_fire_ready <= 1'b1;
          r_state      <= FIRE_READY;
        end
      endcase
    end
  end

  assign o_fire_pulse = r_fire_pulse;
  assign o_fire_ready = r_fire_ready;

endmodule

// File: rtl/joystick_conditioner.sv
// ---------------------------------------------------------------------------
// joystick_conditioner
// Captures PmodJSTK frames on each rising edge of Sample_Tick, derives a
// hysteresis-filtered move direction from X, and emits rate-limited fire
// pulses via jstk_fire_ctrl.
// Build option: JSTK_AUTOFIRE_EN (see jstk_fire_ctrl).
//
// state | meaning
// NONE  | X inside the deadzone, no movement
// RIGHT | X beyond right entry threshold, held until below right exit
// LEFT  | X beyond left entry threshold, held until above left exit
//
// Ports:
//   Clk, Reset_n : board clock, async active-low reset
//   jstk (slave) : Sample_Tick/Jstk_Data in; X_Pos, Y_Pos, Buttons,
//                  Move_Dir, Sample_Valid, Fire_Pulse, Fire_Ready out
// ---------------------------------------------------------------------------
module joystick_conditioner
  import jstk_pkg::*;
#(
  parameter int DEADZONE        = 100,
  parameter int HYST            = 16,
  parameter int COOLDOWN_CYCLES = 25_000_000
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  joystick_conditioner_if.slave  jstk
);

  // 11-bit thresholds keep 512+DEADZONE (up to 1023) and 512-DEADZONE
  // (down to 1) free of wrap.
  localparam logic [10:0] R_ENTRY = 11'(JSTK_CENTER + DEADZONE);
  localparam logic [10:0] R_EXIT  = 11'(JSTK_CENTER + DEADZONE - HYST);
  localparam logic [10:0] L_ENTRY = 11'(JSTK_CENTER - DEADZONE);
  localparam logic [10:0] L_EXIT  = 11'(JSTK_CENTER - DEADZONE + HYST);

  logic        r_tick_q;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [2:0]  r_btn;
  dir_t        r_dir;
  logic        r_valid;

  logic        w_edge;
  logic [10:0] w_x11;
  dir_t        w_dir_nxt;
  logic        w_fire_pulse;
  logic        w_fire_ready;
  logic        w_unused_bits;

  assign w_edge = jstk.Sample_Tick & ~r_tick_q;
  assign w_x11  = {1'b0, get_x(jstk.Jstk_Data)};

  // Frame bits that carry no information for this block.
  assign w_unused_bits = ^{jstk.Jstk_Data[7:3], jstk.Jstk_Data[15:10],
                           jstk.Jstk_Data[31:26]};

  // Direction is decided from the incoming X so it lands in the same cycle
  // as the captured value. Opposite-side entry wins over exit so reversals
  // skip NONE.
  always_comb begin
    w_dir_nxt = r_dir;
    case (r_dir)
      NONE: begin
        if (w_x11 >= R_ENTRY)      w_dir_nxt = RIGHT;
        else if (w_x11 <= L_ENTRY) w_dir_nxt = LEFT;
      end
      RIGHT: begin
        if (w_x11 <= L_ENTRY)      w_dir_nxt = LEFT;
        else if (w_x11 < R_EXIT)   w_dir_nxt = NONE;
      end
      LEFT: begin
        if (w_x11 >= R_ENTRY)      w_dir_nxt = RIGHT;
        else if (w_x11 > L_EXIT)   w_dir_nxt = NONE;
      end
      default: w_dir_nxt = NONE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tick_q <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_btn    <= '0;
      r_dir    <= NONE;
      r_valid  <= 1'b0;
    end else begin
      r_tick_q <= jstk.Sample_Tick;
      r_valid  <= w_edge;
      if (w_edge) begin
        r_x   <= get_x(jstk.Jstk_Data);
        r_y   <= get_y(jstk.Jstk_Data);
        r_btn <= jstk.Jstk_Data[BTN_MSB:BTN_LSB];
        r_dir <= w_dir_nxt;
      end
    end
  end

  jstk_fire_ctrl #(
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES)
  ) u_fire_ctrl (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .sample_edge  (w_edge),
    .fire_bit     (jstk.Jstk_Data[FIRE_BIT]),
    .o_fire_pulse (w_fire_pulse),
    .o_fire_ready (w_fire_ready)
  );

  assign jstk.X_Pos        = r_x;
  assign jstk.Y_Pos        = r_y;
  assign jstk.Buttons      = r_btn;
  assign jstk.Move_Dir     = r_dir;
  assign jstk.Sample_Valid = r_valid;
  assign jstk.Fire_Pulse   = w_fire_pulse;
  assign jstk.Fire_Ready   = w_fire_ready;

endmodule

// File: tb/tb_joystick_conditioner.sv
// ---------------------------------------------------------------------------
// tb_joystick_conditioner
// Two conditioner instances (cooldown 20 and 10 clocks) driven with directed
// and random frames; each output is compared against a reference model that
// applies the threshold rules and the pulse-spacing rule directly.
// ---------------------------------------------------------------------------
module tb_joystick_conditioner;

  localparam int CD_A = 20;
  localparam int CD_B = 10;
  localparam int DZ   = 100;
  localparam int HY   = 16;
`ifdef JSTK_AUTOFIRE_EN
  localparam bit AUTOFIRE = 1'b1;
`else
  localparam bit AUTOFIRE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  joystick_conditioner_if if_a ();
  joystick_conditioner_if if_b ();

  joystick_conditioner #(.COOLDOWN_CYCLES(CD_A)) dut_a (
    .Clk     (clk),
    .Reset_n (rst_n),
    .jstk    (if_a)
  );

  joystick_conditioner #(.COOLDOWN_CYCLES(CD_B)) dut_b (
    .Clk     (clk),
    .Reset_n (rst_n),
    .jstk    (if_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state, one slot per DUT.
  int m_dir [2];
  bit m_prev[2];
  bit m_has [2];
  int m_last[2];
  int m_cd  [2];
  int low_cnt  [2];
  int pulse_cnt[2];

  function automatic logic [39:0] mk(input int x, input int y, input int btn);
    logic [39:0] d;
    logic [9:0]  xv;
    logic [9:0]  yv;
    xv = 10'(x);
    yv = 10'(y);
    d = '0;
    d[23:16] = xv[7:0];
    d[9:8]   = xv[9:8];
    d[39:32] = yv[7:0];
    d[25:24] = yv[9:8];
    d[2:0]   = 3'(btn);
    return d;
  endfunction

  function automatic int next_dir(input int cur, input int x);
    bit r_in, l_in;
    r_in = (x >= 512 + DZ);
    l_in = (x <= 512 - DZ);
    if (cur == 1) return l_in ? 2 : ((x < 512 + DZ - HY) ? 0 : 1);
    if (cur == 2) return r_in ? 1 : ((x > 512 - DZ + HY) ? 0 : 2);
    return r_in ? 1 : (l_in ? 2 : 0);
  endfunction

  function automatic bit exp_ready(input int w);
    return !m_has[w] || (cyc - m_last[w] >= m_cd[w]);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_dir[w]  = 0;
      m_prev[w] = 1'b0;
      m_has[w]  = 1'b0;
      m_last[w] = 0;
    end
    m_cd[0] = CD_A;
    m_cd[1] = CD_B;
  endtask

  task automatic drive(input int w, input logic [39:0] d, input logic t);
    if (w == 0) begin if_a.Jstk_Data = d; if_a.Sample_Tick = t; end
    else        begin if_b.Jstk_Data = d; if_b.Sample_Tick = t; end
  endtask

  task automatic set_tick(input int w, input logic t);
    if (w == 0) if_a.Sample_Tick = t;
    else        if_b.Sample_Tick = t;
  endtask

  task automatic rd(input int w, output logic [9:0] x, output logic [9:0] y,
                    output logic [2:0] b, output logic [1:0] d, output logic v,
                    output logic p, output logic r);
    if (w == 0) begin
      x = if_a.X_Pos; y = if_a.Y_Pos; b = if_a.Buttons; d = if_a.Move_Dir;
      v = if_a.Sample_Valid; p = if_a.Fire_Pulse; r = if_a.Fire_Ready;
    end else begin
      x = if_b.X_Pos; y = if_b.Y_Pos; b = if_b.Buttons; d = if_b.Move_Dir;
      v = if_b.Sample_Valid; p = if_b.Fire_Pulse; r = if_b.Fire_Ready;
    end
  endtask

  // One clock with no sample edge: valid/pulse must stay low, direction
  // must hold, ready follows the cooldown window.
  task automatic idle_cycle(input int w, input string tag);
    logic [9:0] x, y; logic [2:0] b; logic [1:0] d; logic v, p, r; bit er;
    @(posedge clk); @(negedge clk);
    rd(w, x, y, b, d, v, p, r);
    er = exp_ready(w);
    if (!r) low_cnt[w]++;
    if (p)  pulse_cnt[w]++;
    n_cmp += 4;
    if (v !== 1'b0) begin n_bad++; $display("FAIL %s idle_valid: got %b want 0", tag, v); end
    if (p !== 1'b0) begin n_bad++; $display("FAIL %s idle_pulse: got %b want 0", tag, p); end
    if (r !== er)   begin n_bad++; $display("FAIL %s idle_ready: got %b want %b", tag, r, er); end
    if (d !== 2'(m_dir[w])) begin
      n_bad++; $display("FAIL %s idle_dir: got %b want %0d", tag, d, m_dir[w]);
    end
  endtask

  // Present a frame with a rising tick, check the capture cycle against the
  // model, then hold/drop the tick over the remaining gap-1 clocks.
  task automatic do_sample(input int w, input logic [39:0] fr, input int gap,
                           input string tag);
    logic [9:0] x, y; logic [2:0] b; logic [1:0] d; logic v, p, r;
    int ex, ey; bit fb, trig, ep, er;
    drive(w, fr, 1'b1);
    @(posedge clk); @(negedge clk);
    ex = {fr[9:8], fr[23:16]};
    ey = {fr[25:24], fr[39:32]};
    m_dir[w] = next_dir(m_dir[w], ex);
    fb   = fr[1];
    trig = fb && (AUTOFIRE || !m_prev[w]);
    m_prev[w] = fb;
    ep = trig && (!m_has[w] || (cyc - m_last[w] >= m_cd[w] + 1));
    if (ep) begin m_has[w] = 1'b1; m_last[w] = cyc; end
    er = exp_ready(w);
    rd(w, x, y, b, d, v, p, r);
    if (!r) low_cnt[w]++;
    if (p)  pulse_cnt[w]++;
    n_cmp += 7;
    if (v !== 1'b1) begin n_bad++; $display("FAIL %s valid: got %b want 1", tag, v); end
    if (x !== 10'(ex)) begin n_bad++; $display("FAIL %s x_pos: got %0d want %0d", tag, x, ex); end
    if (y !== 10'(ey)) begin n_bad++; $display("FAIL %s y_pos: got %0d want %0d", tag, y, ey); end
    if (b !== fr[2:0]) begin n_bad++; $display("FAIL %s buttons: got %b want %b", tag, b, fr[2:0]); end
    if (d !== 2'(m_dir[w])) begin
      n_bad++; $display("FAIL %s move_dir: got %b want %0d (x=%0d)", tag, d, m_dir[w], ex);
    end
    if (p !== ep) begin n_bad++; $display("FAIL %s fire_pulse: got %b want %b", tag, p, ep); end
    if (r !== er) begin n_bad++; $display("FAIL %s fire_ready: got %b want %b", tag, r, er); end
    for (int k = 1; k < gap; k++) begin
      if (k == (gap + 1) / 2) set_tick(w, 1'b0);
      idle_cycle(w, tag);
    end
    set_tick(w, 1'b0);
  endtask

  task automatic test_reset();
    logic [9:0] x, y; logic [2:0] b; logic [1:0] d; logic v, p, r;
    @(negedge clk);
    rd(0, x, y, b, d, v, p, r);
    n_cmp++;
    if ({x, y, b, d, v, p, r} !== {10'd0, 10'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL reset_init: got x=%0d y=%0d b=%b d=%b v=%b p=%b r=%b want all 0, ready 1",
                        x, y, b, d, v, p, r);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_sample(0, mk(512, 512, 0), 6, "rst_pre");
    do_sample(0, mk(700, 300, 2), 4, "rst_press");
    #1 rst_n = 1'b0;
    #1 rd(0, x, y, b, d, v, p, r);
    n_cmp++;
    if ({x, y, b, d, v, p, r} !== {10'd0, 10'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL reset_mid: got x=%0d y=%0d b=%b d=%b v=%b p=%b r=%b want all 0, ready 1",
                        x, y, b, d, v, p, r);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pulse_cnt[0] = 0;
    for (int i = 0; i < 10; i++) do_sample(0, mk(512, 512, 0), 8, "rst_idle");
    n_cmp++;
    if (pulse_cnt[0] != 0) begin
      n_bad++; $display("FAIL reset_no_pulse: got %0d pulses want 0", pulse_cnt[0]);
    end
  endtask

  task automatic test_capture();
    do_sample(0, 40'hA5_02_3C_01_07, 8, "capture");
    n_cmp += 3;
    if (if_a.X_Pos !== 10'h13C) begin n_bad++; $display("FAIL cap_x: got %h want 13c", if_a.X_Pos); end
    if (if_a.Y_Pos !== 10'h2A5) begin n_bad++; $display("FAIL cap_y: got %h want 2a5", if_a.Y_Pos); end
    if (if_a.Buttons !== 3'b111) begin n_bad++; $display("FAIL cap_btn: got %b want 111", if_a.Buttons); end
  endtask

  task automatic test_hysteresis();
    int xs[5];
    logic [1:0] ed[5];
    xs = '{512, 612, 600, 595, 512};
    ed = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 5; i++) begin
      do_sample(0, mk(xs[i], 512, 0), 6, "hyst");
      n_cmp++;
      if (if_a.Move_Dir !== ed[i]) begin
        n_bad++; $display("FAIL hyst_dir[%0d]: got %b want %b", i, if_a.Move_Dir, ed[i]);
      end
    end
  endtask

  task automatic test_reversal();
    do_sample(0, mk(700, 512, 0), 6, "rev");
    n_cmp++;
    if (if_a.Move_Dir !== 2'b01) begin n_bad++; $display("FAIL rev_right: got %b want 01", if_a.Move_Dir); end
    do_sample(0, mk(300, 512, 0), 6, "rev");
    n_cmp++;
    if (if_a.Move_Dir !== 2'b10) begin n_bad++; $display("FAIL rev_left: got %b want 10", if_a.Move_Dir); end
    do_sample(0, mk(512, 512, 0), 6, "rev_end");
  endtask

  task automatic test_cooldown();
    do_sample(0, mk(512, 512, 0), 30, "cd_pre");
    low_cnt[0]   = 0;
    pulse_cnt[0] = 0;
    do_sample(0, mk(512, 512, 2), 8, "cd_press1");
    do_sample(0, mk(512, 512, 0), 8, "cd_release");
    do_sample(0, mk(512, 512, 2), 8, "cd_press2");
    do_sample(0, mk(512, 512, 0), 30, "cd_post");
    n_cmp += 2;
    if (pulse_cnt[0] != 1) begin n_bad++; $display("FAIL cd_pulses: got %0d want 1", pulse_cnt[0]); end
    if (low_cnt[0] != CD_A) begin n_bad++; $display("FAIL cd_ready_low: got %0d want %0d", low_cnt[0], CD_A); end
  endtask

  task automatic test_held();
    int want;
    want = AUTOFIRE ? 3 : 1;
    do_sample(1, mk(512, 512, 0), 8, "held_pre");
    pulse_cnt[1] = 0;
    for (int i = 0; i < 6; i++) do_sample(1, mk(512, 512, 2), 8, "held");
    do_sample(1, mk(512, 512, 0), 20, "held_post");
    n_cmp++;
    if (pulse_cnt[1] != want) begin
      n_bad++; $display("FAIL held_pulses: got %0d want %0d", pulse_cnt[1], want);
    end
  endtask

  task automatic test_random();
    int bnd[12];
    logic [63:0] rr;
    logic [39:0] fr;
    logic [9:0]  xv;
    bnd = '{411, 412, 413, 427, 428, 429, 595, 596, 597, 611, 612, 613};
    for (int i = 0; i < 60; i++) begin
      rr = {$urandom, $urandom};
      fr = rr[39:0];
      if ($urandom_range(0, 1) == 1) begin
        xv = 10'(bnd[$urandom_range(0, 11)]);
        fr[23:16] = xv[7:0];
        fr[9:8]   = xv[9:8];
      end
      do_sample(0, fr, $urandom_range(2, 30), "rand");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    if_a.Sample_Tick = 1'b0; if_a.Jstk_Data = mk(512, 512, 0);
    if_b.Sample_Tick = 1'b0; if_b.Jstk_Data = mk(512, 512, 0);
    model_reset();
    for (int w = 0; w < 2; w++) begin low_cnt[w] = 0; pulse_cnt[w] = 0; end
    test_reset();
    test_capture();
    test_hysteresis();
    test_reversal();
    test_cooldown();
    test_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
